// File: rtl/s2l_pkg.sv
// Shared types and constants for the stream-to-lite capture path.
package s2l_pkg;
  localparam int S2L_PTR_W = 2;
  localparam int S2L_DEPTH = 2 ** S2L_PTR_W;
  localparam int S2L_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_DISCARD  = 3'd2,
    ST_WAIT_SET = 3'd3,
    ST_WAIT_ACK = 3'd4
  } s2l_cap_state_t;
endpackage

// File: rtl/s2l_capture_ctrl.sv
// Frame sequencer: writes one AXI Stream frame into the register bank, then
// holds the stream off until software has consumed and cleared the ready bit.
module s2l_capture_ctrl
  import s2l_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_PTR_WIDTH        = S2L_PTR_W
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  output logic                          S_AXIS_TREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] incoming_data,
  output logic                          tvalid,
  output logic                          tlast,
  output logic [C_PTR_WIDTH-1:0]        wr_ptr,
  input  logic                          ready,
  output logic [S2L_CNT_W-1:0]          word_count,
  output logic [S2L_CNT_W-1:0]          frame_count,
  output logic [S2L_CNT_W-1:0]          overflow_count
);
  localparam int DEPTH = 2 ** C_PTR_WIDTH;
  localparam logic [C_PTR_WIDTH-1:0] PTR_LAST = C_PTR_WIDTH'(DEPTH - 1);

  s2l_cap_state_t state, state_nxt;
  logic [C_PTR_WIDTH-1:0] ptr, ptr_nxt, wr_at;
  logic hs, wr_en, ovf_inc, tready_nxt;

  assign hs = S_AXIS_TVALID & S_AXIS_TREADY;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_at     = ptr;
    wr_en     = 1'b0;
    ovf_inc   = 1'b0;
    unique case (state)
      ST_IDLE: if (hs) begin
        wr_en = 1'b1;
        wr_at = '0;
        if (S_AXIS_TLAST) begin
          state_nxt = ST_WAIT_SET;
        end else begin
          state_nxt = ST_FILL;
          ptr_nxt   = C_PTR_WIDTH'(1);
        end
      end
      ST_FILL: if (hs) begin
        if (S_AXIS_TLAST) begin
          wr_en     = 1'b1;
          state_nxt = ST_WAIT_SET;
          ptr_nxt   = '0;
        end else if (ptr == PTR_LAST) begin
          // A non-last word at the final slot means the frame is overlong;
          // the slot is reserved for the frame's last word.
          state_nxt = ST_DISCARD;
        end else begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + C_PTR_WIDTH'(1);
        end
      end
      ST_DISCARD: if (hs && S_AXIS_TLAST) begin
        wr_en     = 1'b1;
        wr_at     = PTR_LAST;
        ovf_inc   = 1'b1;
        state_nxt = ST_WAIT_SET;
        ptr_nxt   = '0;
      end
      ST_WAIT_SET: if (ready)  state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (!ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    tready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_FILL) ||
                 (state_nxt == ST_DISCARD);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      S_AXIS_TREADY  <= 1'b0;
      tvalid         <= 1'b0;
      tlast          <= 1'b0;
      wr_ptr         <= '0;
      incoming_data  <= '0;
      word_count     <= '0;
      frame_count    <= '0;
      overflow_count <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      S_AXIS_TREADY <= tready_nxt;
      tvalid        <= wr_en;
      tlast         <= wr_en & S_AXIS_TLAST;
      if (wr_en) begin
        wr_ptr        <= wr_at;
        incoming_data <= S_AXIS_TDATA;
      end
      if (hs)                word_count     <= word_count + S2L_CNT_W'(1);
      if (hs && S_AXIS_TLAST) frame_count   <= frame_count + S2L_CNT_W'(1);
      if (ovf_inc)           overflow_count <= overflow_count + S2L_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_s2l_capture_ctrl.sv
// Self-checking bench: directed frames plus random frames against a
// frame-level reference model and a behavioural bank/software model.
module tb_s2l_capture_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] incoming_data;
  logic        tvalid, tlast;
  logic [1:0]  wr_ptr;
  logic        ready = 1'b0;
  logic [31:0] word_count, frame_count, overflow_count;

  s2l_capture_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_PTR_WIDTH(2)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .incoming_data(incoming_data), .tvalid(tvalid), .tlast(tlast),
    .wr_ptr(wr_ptr), .ready(ready), .word_count(word_count),
    .frame_count(frame_count), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // reference model: frame position, blocking phase, counters
  int k = 0;
  int phase = 0;      // 0 open, 1 waiting for ready set, 2 waiting for ready clear
  bit fresh = 1'b1;   // just out of reset: TREADY still low for one clock
  int m_words = 0, m_frames = 0, m_ovf = 0;
  int cyc_n = 0;
  // bank/software model
  bit pend = 1'b0;
  int hold = 0, hold_left = 0;
  int fall_seen = -100;
  int first_hs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic l, output logic hs);
    logic       exp_v, exp_l;
    logic [1:0] exp_ptr;
    exp_v = 1'b0; exp_l = 1'b0; exp_ptr = '0;
    S_AXIS_TVALID = v; S_AXIS_TDATA = d; S_AXIS_TLAST = l;
    chk("tready", S_AXIS_TREADY, (phase == 0 && !fresh) ? 1 : 0);
    hs = v && phase == 0 && !fresh;
    @(posedge clk);
    cyc_n++;
    fresh = 1'b0;
    if (hs) begin
      m_words++;
      // words beyond slot DEPTH-2 survive only if they end the frame
      if (k < DEPTH - 1 || l) begin
        exp_v = 1'b1; exp_l = l;
        exp_ptr = (k < DEPTH - 1) ? 2'(k) : 2'(DEPTH - 1);
      end
      if (l) begin
        m_frames++;
        if (k >= DEPTH) m_ovf++;
        k = 0; phase = 1;
      end else k++;
    end else if (phase == 1 && ready) phase = 2;
    else if (phase == 2 && !ready) phase = 0;
    @(negedge clk);
    chk("tvalid", tvalid, exp_v);
    chk("tlast", tlast, exp_l);
    if (exp_v) begin
      chk("wr_ptr", wr_ptr, exp_ptr);
      chk("data", incoming_data, d);
    end
    chk("word_count", word_count, m_words);
    chk("frame_count", frame_count, m_frames);
    chk("overflow_count", overflow_count, m_ovf);
    // bank sets ready the cycle after the tlast strobe; software clears after hold
    if (ready) begin
      if (hold_left == 0) begin ready = 1'b0; fall_seen = cyc_n + 1; end
      else hold_left--;
    end
    if (pend) begin ready = 1'b1; hold_left = hold; end
    pend = tvalid && tlast;
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, hs);
  endtask

  // gap_mode: 0 none, 1 one idle cycle before each word, 2 random gaps
  task automatic send(input int len, input logic [31:0] base, input int gap_mode);
    logic hs;
    int tries;
    for (int i = 0; i < len; i++) begin
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle($urandom_range(0, 2));
      hs = 1'b0; tries = 0;
      while (!hs && tries < 200) begin
        cyc(1'b1, base + 32'(i), (i == len - 1), hs);
        tries++;
      end
      if (!hs) begin chk("accept_timeout", {31'b0, hs}, 32'd1); return; end
      if (i == 0) first_hs = cyc_n;
    end
  endtask

  initial begin
    logic hs;
    // reset state
    #2;
    chk("rst_tready", S_AXIS_TREADY, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_counts", word_count | frame_count | overflow_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 4-word frame
    hold = 2;
    send(4, 32'hA0, 0);
    chk("A_words", word_count, 4);
    chk("A_frames", frame_count, 1);
    idle(1);
    chk("A_tready_low", S_AXIS_TREADY, 0);
    idle(8);

    // single-word frame
    send(1, 32'hB0, 0);
    chk("B_frames", frame_count, 2);
    idle(8);

    // 6-word overlong frame
    send(6, 32'hC0, 0);
    chk("C_ovf", overflow_count, 1);
    idle(8);

    // back-to-back with long software hold
    hold = 9;
    send(3, 32'hD0, 0);
    send(2, 32'hE0, 0);
    chk("b2b_accept_lat", 32'(first_hs - fall_seen), 1);
    hold = 2;
    idle(14);

    // TVALID toggling
    send(4, 32'hF0, 1);
    idle(8);

    // reset mid-frame
    cyc(1'b1, 32'h50, 1'b0, hs);
    cyc(1'b1, 32'h51, 1'b0, hs);
    #2 rst = 1'b1;
    #1;
    chk("amid_tready", S_AXIS_TREADY, 0);
    chk("amid_tvalid", tvalid, 0);
    chk("amid_tlast", tlast, 0);
    chk("amid_ptr", wr_ptr, 0);
    chk("amid_data", incoming_data, 0);
    chk("amid_words", word_count, 0);
    chk("amid_frames", frame_count, 0);
    chk("amid_ovf", overflow_count, 0);
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    k = 0; phase = 0; fresh = 1'b1; m_words = 0; m_frames = 0; m_ovf = 0;
    ready = 1'b0; pend = 1'b0; hold_left = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("post_rst_tready", S_AXIS_TREADY, 1);
    chk("post_rst_frames", frame_count, 0);

    // random frames
    for (int f = 0; f < 14; f++) begin
      hold = $urandom_range(0, 5);
      send($urandom_range(1, 7), $urandom, $urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
